ped_button_request: RTL
=======================

Name: ped_button_request

Overview:
- Upstream stage of the pedestrian traffic-light controller. It conditions the raw pedestrian push-button and turns it into a clean, held request level.
- Processing chain: 2-flop synchroniser, then debounce, then press-edge detect, then request latch.
- The request latch is held until the controller acknowledges service, then a lockout window ignores further presses.
- Also drives the "WAIT" indicator lamp and keeps a saturating press counter for bring-up visibility.

Parameters:
- TIMER_SCALE, 16000000, clock ticks per second (16 MHz board clock).
- DEBOUNCE_TICKS, 320000, consecutive stable synchronised cycles required to accept a level change (20 ms). Must be >= 2.
- LOCKOUT_SECONDS, 5, post-acknowledge window during which presses are ignored. LOCKOUT_SECONDS*TIMER_SCALE must fit 30 bits.
- BUTTON_ACTIVE_LOW, 1, 1: pin reads 0 when pressed (pull-up button); 0: pin reads 1 when pressed.

Ports:
- pin3_clk_16mhz  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pin9_ped_button  in  1  raw asynchronous button pin
- ped_ack  in  1  one-cycle pulse from the controller when it enters its pedestrian-green phase
- ped_request  out  1  registered request level to the controller
- pin10_wait_lamp  out  1  WAIT indicator, registered
- press_pulse  out  1  one-cycle pulse per accepted (debounced) press, including ignored ones
- press_count  out  8  saturating count of accepted presses since reset

Behaviour:
- Clock and reset: one clock, pin3_clk_16mhz; rst is synchronous and active-high. All state updates on posedge pin3_clk_16mhz.
- Reset values:
  - Sync flops = released pin level (1 if BUTTON_ACTIVE_LOW, else 0).
  - Debounced level = released; debounce counter = 0; lockout timer = 0.
  - State = IDLE.
  - ped_request = 0, pin10_wait_lamp = 0, press_pulse = 0, press_count = 0.
- Synchroniser: 2 flops, normalised to "pressed=1" after the second flop.
- Debounce:
  - While the synchronised value equals the debounced level, the counter clears to 0.
  - While it differs, the counter increments.
  - When the counter = DEBOUNCE_TICKS-1 and the values still differ, the debounced level takes the new value on that edge and the counter clears.
  - A single differing-then-matching glitch of any length < DEBOUNCE_TICKS causes no change.
- press_pulse: high for exactly the one cycle in which the debounced level transitions released to pressed. Release transitions produce no pulse.
- Latency: first edge sampling a pressed pin to press_pulse = DEBOUNCE_TICKS+2 cycles. ped_request rises one cycle after press_pulse (DEBOUNCE_TICKS+3).
- State machine (3-bit encoding, IDLE=0, PENDING=1, LOCKOUT=2, others decode to IDLE next cycle):
  - IDLE: press_pulse -> PENDING, ped_request<=1. ped_ack is ignored.
  - PENDING: ped_request held at 1. Extra presses are counted only.
    - On ped_ack -> LOCKOUT: ped_request<=0, lockout timer <= LOCKOUT_SECONDS*TIMER_SCALE-1.
  - LOCKOUT: timer decrements each cycle. Presses are counted but do not latch. ped_ack is ignored.
    - When the timer = 0 -> IDLE.
    - A press_pulse in the same cycle as timer=0 is dropped.
- Simultaneous press_pulse and ped_ack in PENDING: the ack wins and the state goes to LOCKOUT.
- pin10_wait_lamp = 1 exactly while the state is PENDING (registered with ped_request).
- press_count: +1 per press_pulse, saturates at 255, never wraps.
- Reset mid-operation:
  - Any state returns to IDLE with outputs cleared in the same edge.
  - A button held through reset is seen as a fresh press DEBOUNCE_TICKS+2 cycles after rst deasserts.

Optional Feature:
- Macro WAIT_BLINK_EN.
- Defined:
  - In PENDING, pin10_wait_lamp toggles every TIMER_SCALE/2 cycles (1 Hz blink), starting lit on the PENDING entry cycle.
  - The blink counter clears on leaving PENDING; the lamp is 0 outside PENDING.
- Undefined: the lamp is steady high in PENDING and the blink counter is not instantiated.

Decomposition:
- Shared package ped_pkg:
  - State encodings (IDLE/PENDING/LOCKOUT, 3-bit).
  - Default TIMER_SCALE.
  - Timer width constant 30.
  - The controller's existing light-state encodings move here as well.
- One sub-module: ped_debounce (synchroniser + debounce counter + press edge detect).
  - Parameters DEBOUNCE_TICKS and BUTTON_ACTIVE_LOW.
  - Outputs a debounced level and press_pulse.
  - The request FSM, lockout timer, lamp and counter stay in ped_button_request.

Test Plan (TIMER_SCALE=10, DEBOUNCE_TICKS=4, LOCKOUT_SECONDS=2, active-low):
- Clean press: pin low from cycle 0 and held -> press_pulse at cycle 6, ped_request and lamp high at cycle 7, press_count=1.
- Bounce: pin low 3 cycles, high 1, low 2, high -> no press_pulse, ped_request stays 0, press_count=0.
- Service: in PENDING, pulse ped_ack -> ped_request=0 next edge. A press during the next 20 cycles -> press_count increments, ped_request stays 0. After 20 cycles the state is IDLE and a new press latches again.
- Simultaneous: press_pulse and ped_ack in the same cycle while PENDING -> LOCKOUT, ped_request=0; ped_ack while IDLE -> no effect.
- Saturation and reset: 300 debounced presses -> press_count=255. Assert rst for 1 cycle while PENDING -> all outputs 0 next edge. Button held through rst -> press_pulse 6 cycles after release.
- WAIT_BLINK_EN defined: in PENDING the lamp toggles every 5 cycles, starting at 1; the lamp is 0 immediately on ped_ack.

Source files
------------

// File: rtl/ped_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ped_pkg
// Description : Shared constants for the pedestrian crossing controller:
//               request FSM encodings, light encodings, timer width.
// Revision    : 1.0 - initial release
// ============================================================================
package ped_pkg;

    localparam int unsigned c_default_timer_scale = 16000000;
    localparam int unsigned c_timer_w             = 30;

    // Request state machine encoding (values 3..7 are illegal and recover to IDLE)
    localparam int unsigned c_state_w  = 3;
    localparam logic [2:0]  c_st_idle    = 3'd0;
    localparam logic [2:0]  c_st_pending = 3'd1;
    localparam logic [2:0]  c_st_lockout = 3'd2;

    // Controller light-state encodings
    localparam logic [1:0]  c_light_car_green = 2'd0;
    localparam logic [1:0]  c_light_car_amber = 2'd1;
    localparam logic [1:0]  c_light_ped_green = 2'd2;
    localparam logic [1:0]  c_light_all_red   = 2'd3;

    // Counter width able to hold 0..n-1
    function automatic int unsigned f_cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ped_debounce.sv
`default_nettype none
// ============================================================================
// Module      : ped_debounce
// Description : Two-flop synchroniser, debounce counter and press-edge pulse.
//               Output level is normalised so that 1 means pressed.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_debounce
    import ped_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS    = 320000,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic pin3_clk_16mhz,
    input  logic rst,
    input  logic button_raw,
    output logic level,
    output logic press_pulse
);

    localparam int unsigned          c_cnt_w    = f_cnt_w(DEBOUNCE_TICKS);
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(DEBOUNCE_TICKS - 1);
    localparam logic                 c_released = BUTTON_ACTIVE_LOW;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic               r_press_pulse;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_pressed;

    assign w_pressed = r_sync2 ^ c_released;

    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            r_sync1       <= c_released;
            r_sync2       <= c_released;
            r_level       <= 1'b0;
            r_level_d     <= 1'b0;
            r_press_pulse <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_sync1       <= button_raw;
            r_sync2       <= r_sync1;
            r_level_d     <= r_level;
            r_press_pulse <= r_level & ~r_level_d;
            // A level change needs DEBOUNCE_TICKS consecutive disagreeing samples
            if (w_pressed == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= w_pressed;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level       = r_level;
    assign press_pulse = r_press_pulse;

endmodule
`default_nettype wire

// File: rtl/ped_button_request.sv
`default_nettype none
// ============================================================================
// Module      : ped_button_request
// Description : Pedestrian button front end: debounced press -> held request,
//               acknowledge lockout, WAIT lamp and saturating press counter.
//               Optional macro WAIT_BLINK_EN blinks the WAIT lamp at 1 Hz.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_button_request
    import ped_pkg::*;
#(
    parameter int unsigned TIMER_SCALE       = c_default_timer_scale,
    parameter int unsigned DEBOUNCE_TICKS    = 320000,
    parameter int unsigned LOCKOUT_SECONDS   = 5,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic       pin3_clk_16mhz,
    input  logic       rst,
    input  logic       pin9_ped_button,
    input  logic       ped_ack,
    output logic       ped_request,
    output logic       pin10_wait_lamp,
    output logic       press_pulse,
    output logic [7:0] press_count
);

    localparam logic [c_timer_w-1:0] c_lock_load =
        c_timer_w'(LOCKOUT_SECONDS * TIMER_SCALE - 1);

    logic                 w_press_pulse;
    logic                 w_level_unused;
    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic [c_timer_w-1:0] r_timer;
    logic [c_timer_w-1:0] w_timer_nxt;
    logic                 r_ped_request;
    logic                 r_wait_lamp;
    logic [7:0]           r_press_count;

    ped_debounce #(
        .DEBOUNCE_TICKS    (DEBOUNCE_TICKS),
        .BUTTON_ACTIVE_LOW (BUTTON_ACTIVE_LOW)
    ) u_debounce (
        .pin3_clk_16mhz (pin3_clk_16mhz),
        .rst            (rst),
        .button_raw     (pin9_ped_button),
        .level          (w_level_unused),
        .press_pulse    (w_press_pulse)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            c_st_idle: begin
                if (w_press_pulse) w_state_nxt = c_st_pending;
            end
            c_st_pending: begin
                // An acknowledge beats a coincident press
                if (ped_ack) begin
                    w_state_nxt = c_st_lockout;
                    w_timer_nxt = c_lock_load;
                end
            end
            c_st_lockout: begin
                if (r_timer == '0) w_state_nxt = c_st_idle;
                else               w_timer_nxt = r_timer - 1'b1;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_timer       <= '0;
            r_ped_request <= 1'b0;
            r_press_count <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_ped_request <= (w_state_nxt == c_st_pending);
            if (w_press_pulse && (r_press_count != 8'hFF)) begin
                r_press_count <= r_press_count + 8'd1;
            end
        end
    end

`ifdef WAIT_BLINK_EN
    localparam logic [c_timer_w-1:0] c_blink_last = c_timer_w'(TIMER_SCALE / 2 - 1);

    logic [c_timer_w-1:0] r_blink_cnt;

    // Lamp lights on PENDING entry, then toggles every half second
    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst || (w_state_nxt != c_st_pending)) begin
            r_blink_cnt <= '0;
            r_wait_lamp <= 1'b0;
        end else if (r_state != c_st_pending) begin
            r_blink_cnt <= '0;
            r_wait_lamp <= 1'b1;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_wait_lamp <= ~r_wait_lamp;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) r_wait_lamp <= 1'b0;
        else     r_wait_lamp <= (w_state_nxt == c_st_pending);
    end
`endif

    assign ped_request     = r_ped_request;
    assign pin10_wait_lamp = r_wait_lamp;
    assign press_pulse     = w_press_pulse;
    assign press_count     = r_press_count;

endmodule
`default_nettype wire
